// File: rtl/wdt_kick_pkg.sv
// Shared constants and FSM state type for the watchdog kick generator.
// Key bytes form the two-write kick sequence; CLEAR is only decoded when fault latching is built in.
package wdt_kick_pkg;

    localparam logic [7:0] KEY0  = 8'h5A;
    localparam logic [7:0] KEY1  = 8'hA5;
    localparam logic [7:0] CLEAR = 8'hC3;

    typedef enum logic {
        IDLE     = 1'b0,
        GOT_KEY0 = 1'b1
    } state_e;

endpackage

// File: rtl/wdt_prescale.sv
// Free-running prescaler that produces a registered one-cycle tick every PRESCALE clocks.
// A clear restarts the count at 0 and suppresses a tick that would coincide with it.
module wdt_prescale #(
    parameter int PRESCALE_W = 16,
    parameter int PRESCALE   = 40000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam logic [PRESCALE_W-1:0] LAST = PRESCALE_W'(PRESCALE - 1);

    logic [PRESCALE_W-1:0] count_q, count_d;
    logic                  tick_q, tick_d;
    logic                  terminal;

    always_comb begin
        terminal = (count_q == LAST);
        count_d  = (clr || terminal) ? '0 : count_q + 1'b1;
        tick_d   = terminal && !clr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tick_q  <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/wdt_kick.sv
// Host-side kick generator for the servo watchdog: key-sequence decode, count tick, fault status.
// Build with WDT_KICK_FAULT_LATCH_EN to make fault sticky and clearable by a CLEAR write.
module wdt_kick
    import wdt_kick_pkg::*;
#(
    parameter int PRESCALE_W = 16,
    parameter int PRESCALE   = 40000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_stb,
    input  logic [7:0] wr_data,
    input  logic       wdt_out,
    output logic       ena,
    output logic       cnt,
    output logic       armed,
    output logic       fault,
    output logic       seq_err
);

    state_e state_q;
    logic   ena_q, seq_err_q, armed_q, fault_q, fault_d;
    logic   wdt_sync_q;
    logic   kick;

    // Decoded combinationally so the prescaler clears on the same edge that raises ena.
    assign kick = wr_stb && (state_q == GOT_KEY0) && (wr_data == KEY1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ena_q     <= 1'b0;
            seq_err_q <= 1'b0;
        end else begin
            ena_q     <= kick;
            seq_err_q <= 1'b0;
            if (wr_stb) begin
                case (state_q)
                    IDLE: begin
                        if (wr_data == KEY0) begin
                            state_q <= GOT_KEY0;
                        end else if (wr_data == KEY1) begin
                            seq_err_q <= 1'b1;
                        end
                    end
                    GOT_KEY0: begin
                        if (wr_data == KEY1) begin
                            state_q <= IDLE;
                        end else if (wr_data != KEY0) begin
                            seq_err_q <= 1'b1;
                            state_q   <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

`ifdef WDT_KICK_FAULT_LATCH_EN
    logic wdt_prev_q;
    logic clear_wr;

    assign clear_wr = wr_stb && (state_q == IDLE) && (wr_data == CLEAR);

    // A new expiry outranks a simultaneous CLEAR write.
    always_comb begin
        fault_d = fault_q;
        if (wdt_sync_q && !wdt_prev_q && armed_q) begin
            fault_d = 1'b1;
        end else if (clear_wr) begin
            fault_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdt_prev_q <= 1'b0;
        end else begin
            wdt_prev_q <= wdt_sync_q;
        end
    end
`else
    assign fault_d = wdt_sync_q && armed_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdt_sync_q <= 1'b0;
            armed_q    <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            wdt_sync_q <= wdt_out;
            armed_q    <= armed_q || kick;
            fault_q    <= fault_d;
        end
    end

    wdt_prescale #(
        .PRESCALE_W (PRESCALE_W),
        .PRESCALE   (PRESCALE)
    ) u_prescale (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (kick),
        .tick  (cnt)
    );

    assign ena     = ena_q;
    assign seq_err = seq_err_q;
    assign armed   = armed_q;
    assign fault   = fault_q;

endmodule

// File: tb/tb_wdt_kick.sv
// Directed bench for wdt_kick with PRESCALE = 4; expected values are worked out by hand per step.
module tb_wdt_kick;

    logic       clk;
    logic       rst_n;
    logic       wr_stb;
    logic [7:0] wr_data;
    logic       wdt_out;
    logic       ena, cnt, armed, fault, seq_err;

    int checks = 0;
    int errors = 0;

    wdt_kick #(
        .PRESCALE_W (16),
        .PRESCALE   (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_stb  (wr_stb),
        .wr_data (wr_data),
        .wdt_out (wdt_out),
        .ena     (ena),
        .cnt     (cnt),
        .armed   (armed),
        .fault   (fault),
        .seq_err (seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance one active edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle strobe; on return the edge that sampled it has just passed.
    task automatic write(input logic [7:0] d);
        wr_stb  = 1'b1;
        wr_data = d;
        step();
        wr_stb  = 1'b0;
        wr_data = 8'h00;
    endtask

    initial begin
        rst_n   = 1'b0;
        wr_stb  = 1'b0;
        wr_data = 8'h00;
        wdt_out = 1'b0;

        // Reset state
        step();
        step();
        check("rst_ena", ena, 1'b0);
        check("rst_cnt", cnt, 1'b0);
        check("rst_armed", armed, 1'b0);
        check("rst_fault", fault, 1'b0);
        check("rst_seq_err", seq_err, 1'b0);
        rst_n = 1'b1;

        // Free-running tick: high after the 4th and 8th edge following release
        for (int i = 0; i < 8; i++) begin
            step();
            $display("free-run edge %0d cnt=%b", i + 1, cnt);
            check($sformatf("free_cnt_%0d", i + 1), cnt, (i % 4) == 3);
        end
        check("free_ena", ena, 1'b0);
        check("free_armed", armed, 1'b0);
        check("free_fault", fault, 1'b0);

        // Valid kick: 5A then A5
        write(8'h5A);
        $display("write 5A ena=%b seq_err=%b", ena, seq_err);
        check("kick1_no_early_ena", ena, 1'b0);
        write(8'hA5);
        $display("write A5 ena=%b armed=%b", ena, armed);
        check("kick1_ena", ena, 1'b1);
        check("kick1_armed", armed, 1'b1);
        check("kick1_seq_err", seq_err, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 0) check("kick1_ena_drop", ena, 1'b0);
            check($sformatf("kick1_cnt_%0d", i + 1), cnt, i == 3);
        end

        // 5A then 00 -> seq_err
        write(8'h5A);
        check("bad2_first_seq_err", seq_err, 1'b0);
        write(8'h00);
        $display("write 5A,00 seq_err=%b ena=%b", seq_err, ena);
        check("bad2_seq_err", seq_err, 1'b1);
        check("bad2_ena", ena, 1'b0);
        step();
        check("bad2_seq_err_drop", seq_err, 1'b0);

        // Ignored byte in IDLE, then lone A5 -> seq_err
        write(8'h77);
        check("ignored_seq_err", seq_err, 1'b0);
        write(8'hA5);
        $display("write 77,A5 seq_err=%b ena=%b", seq_err, ena);
        check("lone_a5_seq_err", seq_err, 1'b1);
        check("lone_a5_ena", ena, 1'b0);
        step();
        check("lone_a5_seq_err_drop", seq_err, 1'b0);

        // 5A,5A,A5 -> single kick, no error
        write(8'h5A);
        write(8'h5A);
        check("restart_seq_err", seq_err, 1'b0);
        check("restart_no_ena", ena, 1'b0);
        write(8'hA5);
        $display("write 5A,5A,A5 ena=%b seq_err=%b", ena, seq_err);
        check("restart_ena", ena, 1'b1);
        check("restart_seq_err2", seq_err, 1'b0);

        // Kick landing on prescaler count 3: previous kick edge left the count at 0
        write(8'h5A);
        check("align_cnt_1", cnt, 1'b0);
        step();
        check("align_cnt_2", cnt, 1'b0);
        step();
        check("align_cnt_3", cnt, 1'b0);
        write(8'hA5);
        $display("aligned kick ena=%b cnt=%b", ena, cnt);
        check("align_ena", ena, 1'b1);
        check("align_cnt_suppressed", cnt, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("align_after_cnt_%0d", i + 1), cnt, i == 3);
        end

        // Fault from the watchdog while armed
        wdt_out = 1'b1;
        step();
        check("fault_lat1", fault, 1'b0);
        step();
        $display("wdt_out rise fault=%b", fault);
        check("fault_set", fault, 1'b1);
        wdt_out = 1'b0;
        step();
        step();
`ifdef WDT_KICK_FAULT_LATCH_EN
        $display("wdt_out fall fault=%b (sticky)", fault);
        check("fault_sticky", fault, 1'b1);
        write(8'hC3);
        $display("write C3 fault=%b armed=%b", fault, armed);
        check("fault_cleared", fault, 1'b0);
        check("clear_keeps_armed", armed, 1'b1);
`else
        $display("wdt_out fall fault=%b (follows)", fault);
        check("fault_follows", fault, 1'b0);
        write(8'hC3);
        $display("write C3 seq_err=%b ena=%b", seq_err, ena);
        check("c3_ignored_seq_err", seq_err, 1'b0);
        check("c3_ignored_ena", ena, 1'b0);
`endif

        // Async reset while waiting for KEY1
        write(8'h5A);
        rst_n = 1'b0;
        #1;
        $display("async reset armed=%b ena=%b", armed, ena);
        check("arst_armed", armed, 1'b0);
        check("arst_ena", ena, 1'b0);
        check("arst_fault", fault, 1'b0);
        check("arst_cnt", cnt, 1'b0);
        #1;
        rst_n = 1'b1;
        write(8'hA5);
        $display("post-reset A5 seq_err=%b ena=%b", seq_err, ena);
        check("arst_a5_seq_err", seq_err, 1'b1);
        check("arst_a5_ena", ena, 1'b0);
        check("arst_a5_armed", armed, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wdt_kick.md
# wdt_kick

Host-side kick generator for the pluto_servo watchdog: it turns host bus writes into the watchdog's clear pulse and supplies its count tick. It decodes a two-byte key sequence from the host write strobe, emits a one-cycle `ena` to the watchdog, and generates the prescaled `cnt` tick. It also reports watchdog expiry to the host as a status flag. It sits between the EPP register decode and the `wdt` instance.

## Interface
- PRESCALE_W, 16: prescaler counter width.
- PRESCALE, 40000: clk cycles per `cnt` tick. Legal range 2..2^PRESCALE_W-1.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- wr_stb  in  1  one-cycle host write strobe for this register.
- wr_data  in  8  host write data, valid with `wr_stb`.
- wdt_out  in  1  timeout output from the watchdog.
- ena  out  1  one-cycle watchdog clear/arm pulse.
- cnt  out  1  one-cycle watchdog count tick.
- armed  out  1  set after the first valid kick.
- fault  out  1  watchdog expired while armed.
- seq_err  out  1  one-cycle pulse on a key-sequence violation.
- One clock; reset is asynchronous and active-low.

## Operation
- Key constants: KEY0 = 8'h5A, KEY1 = 8'hA5, CLEAR = 8'hC3.
- FSM states and transitions:
  - IDLE:
    - KEY0 write -> GOT_KEY0.
    - KEY1 write -> `seq_err`, stay IDLE.
    - Any other write -> ignored, stay IDLE. CLEAR is handled under Configuration.
  - GOT_KEY0:
    - KEY1 write -> kick, then IDLE.
    - KEY0 write -> stay GOT_KEY0 (sequence restart, no error).
    - Any other write -> `seq_err`, then IDLE.
  - No timeout in GOT_KEY0: the FSM waits indefinitely for the next write.
- Kick actions:
  - `ena` = 1 for exactly one cycle.
  - Prescaler cleared to 0.
  - `armed` set.
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps to 0.
  - `cnt` = 1 for one cycle on the cycle the counter is at PRESCALE-1.
  - The watchdog therefore expires 127×PRESCALE cycles (±1) after a kick.
- `armed`: cleared only by reset.
- Fault source: `wdt_out` is registered once. A rising edge of the registered value while `armed` = 1 is the fault event.

## Timing
- Reset values: `ena` = 0, `cnt` = 0, `armed` = 0, `fault` = 0, `seq_err` = 0; FSM = IDLE; prescaler = 0; `wdt_out` register = 0.
- All outputs are registered.
- `ena` asserts the cycle after the `wr_stb` carrying KEY1. `seq_err` has the same one-cycle latency.
- `fault` asserts 2 cycles after `wdt_out` rises: one cycle for the sync register, one for the output register.
- Kick coincident with prescaler terminal count: prescaler clears and `cnt` is not pulsed that cycle.
- Fault set and CLEAR on the same cycle: set wins.
- Back-to-back `wr_stb` on consecutive cycles is legal and processed every cycle.
- `rst_n` asserted mid-sequence:
  - FSM returns to IDLE at once.
  - Any pending `ena` is dropped.
  - Prescaler is zeroed.

## Configuration
- `WDT_KICK_FAULT_LATCH_EN` defined:
  - `fault` is sticky.
  - A CLEAR write in IDLE clears `fault` (one cycle later) and does not clear `armed`.
  - A kick alone does not clear `fault`.
- `WDT_KICK_FAULT_LATCH_EN` undefined:
  - `fault` = registered `wdt_out` AND `armed`, i.e. it follows the watchdog and drops on the next kick.
  - CLEAR is an ordinary ignored byte.

## Structure
- Package `wdt_kick_pkg` holds:
  - KEY0, KEY1 and CLEAR constants.
  - The FSM state typedef (IDLE, GOT_KEY0).
- One sub-module, `wdt_prescale`:
  - Parameterised PRESCALE_W/PRESCALE.
  - Inputs: clk, rst_n, `clr`.
  - Output: registered `tick`.
- The top level holds the FSM, the `armed`/`fault` logic and the `wdt_out` register.

## Test plan
- Reset, PRESCALE = 4: no writes -> `cnt` pulses every 4th cycle, first pulse 4 cycles after reset release; `ena`, `armed`, `fault` stay 0.
- Write 8'h5A, then 8'hA5 -> `ena` high exactly one cycle, the cycle after the 8'hA5 strobe; `armed` = 1; next `cnt` pulse 4 cycles after the kick.
- Sequences 8'h5A, 8'h00 and a lone 8'hA5 -> `seq_err` pulses once for each; no `ena`. Sequence 8'h5A, 8'h5A, 8'hA5 -> one `ena`, no `seq_err`.
- Armed, then drive `wdt_out` 0->1 -> `fault` = 1 two cycles later.
  - With the macro: `fault` holds after `wdt_out` falls; 8'hC3 clears it.
  - Without the macro: `fault` follows `wdt_out` low.
- KEY1 strobe aligned so that the kick coincides with prescaler count 3 -> no `cnt` that cycle; prescaler restarts from 0.
- `rst_n` pulsed low while in GOT_KEY0 -> all outputs 0 asynchronously; a following 8'hA5 write yields `seq_err`, not `ena`.
